fifo_sync_ctrl: RTL and testbench

Single-clock pointer and flag controller that sequences the `fifo_memory` dual-port RAM as a synchronous FIFO. It converts requester `push`/`pop` strobes into gated `wr_en`/`rd_en` and addresses, maintains occupancy and status flags, tracks the RAM's one-cycle read latency with `rd_valid`, and records overflow and underflow attempts. It sits between the producer/consumer logic and the `fifo_memory` instance, with both RAM clocks tied to `clk`.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_sync_ctrl_if.sv | 42 ++++
 rtl/fifo_ptr.sv | 24 ++
 rtl/fifo_sync_ctrl.sv | 112 +++++++++++
 tb/tb_fifo_sync_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and status bundle for the synchronous FIFO controller.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 6;

    // Status flags grouped so they can be built and routed as one value.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_sync_ctrl_if.sv
// Requester-side handshake, RAM control and status bundle of fifo_sync_ctrl.
interface fifo_sync_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);

    // Requests from producer/consumer logic.
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  clear_err;

    // RAM sequencing.
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  rd_valid;

    // Occupancy and status.
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, pop, flush, clear_err,
        input  wr_en, rd_en, waddr, raddr, rd_valid,
        input  count, full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  push, pop, flush, clear_err,
        output wr_en, rd_en, waddr, raddr, rd_valid,
        output count, full, empty, almost_full, almost_empty, overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping pointer register with increment enable and synchronous clear.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_ADDR_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    // Advance by one on each accepted access; reset and clear both return to zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Pointer and flag controller sequencing a dual-port RAM as a synchronous FIFO.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// NOTE: only control state is reset; RAM contents are left untouched because
// the pointers make stale words unreachable.
module fifo_sync_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH,
    parameter int AFULL_THRESH  = 60,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    fifo_sync_ctrl_if.slave  bus
);

    localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    // The RAM word width only matters to the memory; reject a meaningless one early.
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("fifo_sync_ctrl: DATA_WIDTH must be at least 1");
    end

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic [ADDR_WIDTH:0] count;
    logic                wr_go;
    logic                rd_go;
    logic                overflow_q;
    logic                underflow_q;
    logic                rd_valid_q;
    fifo_status_t        status;

    // Occupancy and flags derived purely from registered state.
    always_comb begin
        // NOTE: every output of this block is assigned first, so no latch can form.
        count               = wptr - rptr;
        status              = '0;
        status.empty        = (wptr == rptr);
        status.full         = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                              (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
        status.almost_full  = (count >= AFULL_LVL);
        status.almost_empty = (count <= AEMPTY_LVL);
        status.overflow     = overflow_q;
        status.underflow    = underflow_q;
    end

    // Flush wins over both requests; flags use current state, so a pop at full
    // is accepted while the simultaneous push is refused, and vice versa at empty.
    assign wr_go = bus.push & ~status.full  & ~bus.flush;
    assign rd_go = bus.pop  & ~status.empty & ~bus.flush;

    fifo_ptr #(.WIDTH(ADDR_WIDTH + 1)) u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (bus.flush),
        .inc (wr_go),
        .ptr (wptr)
    );

    fifo_ptr #(.WIDTH(ADDR_WIDTH + 1)) u_rptr (
        .clk (clk),
        .rst (rst),
        .clr (bus.flush),
        .inc (rd_go),
        .ptr (rptr)
    );

    // Sticky error capture; a new error in the same cycle as clear_err stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.push & status.full & ~bus.flush) begin
                overflow_q <= 1'b1;
            end else if (bus.clear_err) begin
                overflow_q <= 1'b0;
            end
            if (bus.pop & status.empty & ~bus.flush) begin
                underflow_q <= 1'b1;
            end else if (bus.clear_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    // Track the RAM's one-cycle read latency; reset and flush cancel a read in flight.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_go;
        end
    end

    assign bus.wr_en        = wr_go;
    assign bus.rd_en        = rd_go;
    assign bus.waddr        = wptr[ADDR_WIDTH-1:0];
    assign bus.raddr        = rptr[ADDR_WIDTH-1:0];
    assign bus.rd_valid     = rd_valid_q;
    assign bus.count        = count;
    assign bus.full         = status.full;
    assign bus.empty        = status.empty;
    assign bus.almost_full  = status.almost_full;
    assign bus.almost_empty = status.almost_empty;
    assign bus.overflow     = status.overflow;
    assign bus.underflow    = status.underflow;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed bench for fifo_sync_ctrl with a behavioural RAM and a data scoreboard.
module tb_fifo_sync_ctrl;

    localparam int AW    = 6;
    localparam int DEPTH = 2**AW;

    logic clk;
    logic rst;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] mem [DEPTH];

    fifo_sync_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_sync_ctrl #(
        .DATA_WIDTH    (8),
        .ADDR_WIDTH    (AW),
        .AFULL_THRESH  (60),
        .AEMPTY_THRESH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for fifo_memory: synchronous write, registered read.
    always @(posedge clk) begin
        if (bus.wr_en) mem[bus.waddr] <= data_in;
        if (bus.rd_en) data_out <= mem[bus.raddr];
    end

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int         m_count = 0;
    int         m_wr    = 0;
    int         m_rd    = 0;
    logic       m_ovf   = 1'b0;
    logic       m_udf   = 1'b0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    logic [7:0] sb [$];
    int         run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, check gated enables, clock, update model, check state.
    task automatic cycle(input logic p, input logic q, input logic f, input logic c,
                         input logic r, input logic [7:0] d);
        logic exp_wr, exp_rd, set_ovf, set_udf;
        rst = r; bus.push = p; bus.pop = q; bus.flush = f; bus.clear_err = c; data_in = d;
        #1;
        exp_wr  = p && (m_count < DEPTH) && !f;
        exp_rd  = q && (m_count > 0) && !f;
        set_ovf = p && (m_count == DEPTH) && !f;
        set_udf = q && (m_count == 0) && !f;
        check("wr_en", bus.wr_en, exp_wr);
        check("rd_en", bus.rd_en, exp_rd);
        @(posedge clk);
        if (r) begin
            m_count = 0; m_wr = 0; m_rd = 0; m_ovf = 1'b0; m_udf = 1'b0;
            exp_valid = 1'b0; sb.delete();
        end else begin
            if (f) begin
                m_count = 0; m_wr = 0; m_rd = 0; exp_valid = 1'b0; sb.delete();
            end else begin
                exp_valid = exp_rd;
                if (exp_rd) begin exp_data = sb.pop_front(); m_rd++; m_count--; end
                if (exp_wr) begin sb.push_back(d); m_wr++; m_count++; end
            end
            m_ovf = set_ovf ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_udf = set_udf ? 1'b1 : (c ? 1'b0 : m_udf);
        end
        #1;
        check("count",        bus.count,        m_count);
        check("empty",        bus.empty,        m_count == 0);
        check("full",         bus.full,         m_count == DEPTH);
        check("almost_full",  bus.almost_full,  m_count >= 60);
        check("almost_empty", bus.almost_empty, m_count <= 4);
        check("overflow",     bus.overflow,     m_ovf);
        check("underflow",    bus.underflow,    m_udf);
        check("rd_valid",     bus.rd_valid,     exp_valid);
        check("waddr",        bus.waddr,        m_wr % DEPTH);
        check("raddr",        bus.raddr,        m_rd % DEPTH);
        if (exp_valid) check("rd_data", data_out, exp_data);
    endtask

    initial begin
        // Reset, then idle.
        cycle(0, 0, 0, 0, 1, 8'h00);
        cycle(0, 0, 0, 0, 1, 8'h00);
        cycle(0, 0, 0, 0, 0, 8'h00);
        check("reset_empty", bus.empty, 1'b1);
        check("reset_aempty", bus.almost_empty, 1'b1);

        // Fill to full, then one rejected push.
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 0, 0, 8'(i));
        check("fill_full", bus.full, 1'b1);
        check("fill_waddr_wrap", bus.waddr, 0);
        cycle(1, 0, 0, 0, 0, 8'hEE);
        check("fill_overflow", bus.overflow, 1'b1);
        cycle(0, 0, 0, 1, 0, 8'h00);

        // Drain with continuous rd_valid, then one rejected pop.
        run = 0;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, 0, 0, 0, 8'h00);
            if (bus.rd_valid) run++;
        end
        check("drain_valid_run", run, DEPTH);
        cycle(0, 1, 0, 0, 0, 8'h00);
        check("drain_underflow", bus.underflow, 1'b1);
        cycle(0, 0, 0, 1, 0, 8'h00);

        // Simultaneous push/pop at count 10 keeps count and order.
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0, 8'(8'h40 + i));
        for (int i = 0; i < 5; i++)  cycle(1, 1, 0, 0, 0, 8'(8'h50 + i));
        check("simul_count10", bus.count, 10);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0, 8'h00);
        cycle(0, 0, 0, 0, 0, 8'h00);

        // Simultaneous push/pop at full, then overflow racing clear_err.
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 0, 0, 8'(8'h80 + i));
        cycle(1, 1, 0, 0, 0, 8'hC0);
        check("simul_full_count", bus.count, 63);
        check("simul_full_ovf", bus.overflow, 1'b1);
        cycle(1, 0, 0, 0, 0, 8'hC1);
        cycle(1, 0, 0, 1, 0, 8'hC2);
        check("clr_race_ovf", bus.overflow, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0, 0, 8'h00);

        // Simultaneous push/pop at empty, then clear_err alone.
        cycle(1, 1, 0, 0, 0, 8'hD0);
        check("simul_empty_count", bus.count, 1);
        check("simul_empty_udf", bus.underflow, 1'b1);
        cycle(0, 0, 0, 1, 0, 8'h00);
        check("clr_ovf", bus.overflow, 1'b0);
        check("clr_udf", bus.underflow, 1'b0);
        cycle(0, 1, 0, 0, 0, 8'h00);

        // Flush at count 20 with a read in flight; errors survive.
        cycle(0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0, 0, 8'(8'h10 + i));
        cycle(0, 1, 0, 0, 0, 8'h00);
        cycle(0, 1, 1, 0, 0, 8'h00);
        check("flush_count", bus.count, 0);
        check("flush_rd_valid", bus.rd_valid, 1'b0);
        check("flush_keeps_udf", bus.underflow, 1'b1);

        // Reset mid-stream with a pop and push in the reset cycle.
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 8'(8'h20 + i));
        cycle(0, 1, 0, 0, 0, 8'h00);
        cycle(1, 1, 0, 0, 1, 8'h99);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        check("rst_udf", bus.underflow, 1'b0);
        cycle(1, 0, 0, 0, 0, 8'hA5);
        cycle(0, 1, 0, 0, 0, 8'h00);
        cycle(0, 0, 0, 0, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
